cs_bus_sequencer: RTL

- Bus-cycle sequencer sitting directly upstream of the high-address chip-select decoder.
- Accepts single read/write requests from the internal master and drives the 3-bit high-address code (addr_H) that the decoder turns into active-low CS1..CS4.
- Holds addr_H stable for the whole cycle and times OE_n/WE_n with fixed setup/access/hold wait states.
- Parks addr_H on an unmapped code when idle, so all chip selects stay deasserted.

---
 rtl/cs_map_pkg.sv | 25 ++
 rtl/cs_wait_timer.sv | 27 ++
 rtl/cs_bus_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cs_map_pkg.sv
// rtl/cs_map_pkg.sv - shared state encodings, chip codes and address-map helper for the cs bus sequencer
package cs_map_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Chip codes seen by the high-address decoder (CS1..CS4)
  localparam logic [2:0] CHIP1     = 3'b100;
  localparam logic [2:0] CHIP2     = 3'b101;
  localparam logic [2:0] CHIP3     = 3'b010;
  localparam logic [2:0] CHIP4     = 3'b011;
  // Unmapped code parked on addr_H while idle so every chip select stays high
  localparam logic [2:0] PARK_CODE = 3'b000;

  function automatic logic is_mapped(input logic [2:0] code);
    return (code == CHIP1) || (code == CHIP2) || (code == CHIP3) || (code == CHIP4);
  endfunction

endpackage

// File: rtl/cs_wait_timer.sv
// rtl/cs_wait_timer.sv - loadable down-counter with zero flag for bus-cycle wait states
module cs_wait_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and rest at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cs_bus_sequencer.sv
// rtl/cs_bus_sequencer.sv - chip-select bus-cycle sequencer; CS_EXT_WAIT_EN adds ready_in to stretch ACCESS
module cs_bus_sequencer
  import cs_map_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic [2:0]  addr_H,
  output logic [12:0] bus_addr,
  output logic        OE_n,
  output logic        WE_n,
  output logic [7:0]  data_out,
  output logic        data_oe,
`ifdef CS_EXT_WAIT_EN
  input  logic        ready_in,
`endif
  input  logic [7:0]  data_in
);

  // Counter reload values: each phase lasts *_CYC cycles, so load one less
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t           state;
  logic             we_q;
  logic             zero;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             access_exit;

`ifdef CS_EXT_WAIT_EN
  assign access_exit = zero && ready_in;
`else
  assign access_exit = zero;
`endif

  // Reload the wait timer on every transition into a timed phase
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: begin
        if (req && is_mapped(addr[15:13])) begin
          load     = 1'b1;
          load_val = SETUP_LD;
        end
      end
      SETUP: begin
        if (zero) begin
          load     = 1'b1;
          load_val = ACCESS_LD;
        end
      end
      ACCESS: begin
        if (access_exit) begin
          load     = 1'b1;
          load_val = HOLD_LD;
        end
      end
      default: ;
    endcase
  end

  cs_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // Bus-cycle FSM; all bus-facing outputs are registered and change only on phase edges
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      addr_H   <= PARK_CODE;
      bus_addr <= '0;
      OE_n     <= 1'b1;
      WE_n     <= 1'b1;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            we_q <= we;
            if (is_mapped(addr[15:13])) begin
              state    <= SETUP;
              addr_H   <= addr[15:13];
              bus_addr <= addr[12:0];
              // Write data is driven from SETUP so it is settled before WE_n falls
              if (we) begin
                data_out <= wdata;
                data_oe  <= 1'b1;
              end
            end else begin
              state <= ERR;
              ack   <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (zero) begin
            state <= ACCESS;
            if (we_q) WE_n <= 1'b0;
            else      OE_n <= 1'b0;
          end
        end
        ACCESS: begin
          if (access_exit) begin
            state <= HOLD;
            OE_n  <= 1'b1;
            WE_n  <= 1'b1;
            if (!we_q) rdata <= data_in;
          end
        end
        HOLD: begin
          if (zero) begin
            state   <= DONE;
            ack     <= 1'b1;
            addr_H  <= PARK_CODE;
            data_oe <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
